// File: rtl/fp_div_pkg.sv
// fp_div_pkg: shared types and sizing helpers for the fixed-point divider.
// Provides the FSM state enum, width/iteration helpers and Q16.16 saturation values.
package fp_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } fp_div_state_e;

  localparam int IW_DEF = 16;
  localparam int QW_DEF = 16;
  localparam int W_DEF  = IW_DEF + QW_DEF;

  localparam logic [W_DEF-1:0] Q_MAX_DEF = {1'b0, {(W_DEF-1){1'b1}}};
  localparam logic [W_DEF-1:0] Q_MIN_DEF = {1'b1, {(W_DEF-1){1'b0}}};

  function automatic int calc_w(input int iw, input int qw);
    return iw + qw;
  endfunction

  // One step per quotient bit, plus a guard bit when rounding.
  function automatic int calc_n(input int iw, input int qw, input int rnd);
    return iw + qw + qw + rnd;
  endfunction

endpackage

// File: rtl/fp_div_step.sv
// fp_div_step: one combinational restoring-division iteration.
// Ports: rem_i/bit_i/div_i in, rem_o (next remainder) and qbit_o (quotient bit) out.
module fp_div_step
  import fp_div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W:0] rem_i,
  input  logic       bit_i,
  input  logic [W:0] div_i,
  output logic [W:0] rem_o,
  output logic       qbit_o
);

  logic [W+1:0] trial;
  logic [W+1:0] diff;
  logic         unused_top;

  assign trial  = {rem_i, bit_i};
  assign diff   = trial - {1'b0, div_i};
  assign qbit_o = trial >= {1'b0, div_i};
  assign rem_o  = qbit_o ? diff[W:0] : trial[W:0];

  // The remainder stays below the divisor, so the top bit is always zero.
  assign unused_top = diff[W+1] ^ trial[W+1];

endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential radix-2 restoring signed Q(IW.QW) divider with saturation.
// Ports: clk, rst_n, in_valid/in_ready, a, b, out_valid/out_ready, q, clipping, div_zero; macro FP_DIV_ROUND_EN.
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int QW = QW_DEF,
  localparam int W = calc_w(IW, QW)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q,
  output logic         clipping,
  output logic         div_zero
);

`ifdef FP_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  localparam int N  = calc_n(IW, QW, RND);
  localparam int CW = $clog2(N + 1);
  localparam int MW = W + QW + 1;

  localparam logic [W-1:0] QMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] QMIN = {1'b1, {(W-1){1'b0}}};

  fp_div_state_e state_q;

  // dq_q shifts dividend bits out of the top and quotient bits in at the bottom.
  logic [N-1:0]  dq_q;
  logic [W:0]    rem_q;
  logic [W:0]    div_q;
  logic [CW-1:0] cnt_q;
  logic          sign_q;
  logic          dz_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [W-1:0]  q_q;
  logic          clip_q;
  logic          dzo_q;

  logic [W:0]    a_mag;
  logic [W:0]    b_mag;
  logic [N-1:0]  dq_load;
  logic [W:0]    rem_nx;
  logic          qbit;

  logic [MW-1:0] mag;
  logic [MW-1:0] lim;
  logic [W-1:0]  fix_q;
  logic          fix_clip;

  assign a_mag   = a[W-1] ? -{a[W-1], a} : {1'b0, a};
  assign b_mag   = b[W-1] ? -{b[W-1], b} : {1'b0, b};
  assign dq_load = N'(a_mag) << (N - W);

  fp_div_step #(
    .W(W)
  ) u_step (
    .rem_i (rem_q),
    .bit_i (dq_q[N-1]),
    .div_i (div_q),
    .rem_o (rem_nx),
    .qbit_o(qbit)
  );

  always_comb begin
`ifdef FP_DIV_ROUND_EN
    // Guard bit added to the magnitude: round half away from zero.
    mag = MW'(dq_q[N-1:1]) + MW'(dq_q[0]);
`else
    mag = MW'(dq_q);
`endif
    lim = MW'(1) << (W - 1);
    if (!sign_q) begin
      lim = lim - MW'(1);
    end
    fix_q    = '0;
    fix_clip = 1'b0;
    if (dz_q) begin
      // The dividend was never shifted, so zero here means a was zero.
      if (dq_q != '0) begin
        fix_q    = sign_q ? QMIN : QMAX;
        fix_clip = 1'b1;
      end
    end else if (mag > lim) begin
      fix_q    = sign_q ? QMIN : QMAX;
      fix_clip = 1'b1;
    end else begin
      fix_q = sign_q ? -mag[W-1:0] : mag[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dq_q        <= '0;
      rem_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      dz_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      clip_q      <= 1'b0;
      dzo_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= a[W-1] ^ b[W-1];
            dz_q       <= (b == '0);
            dq_q       <= dq_load;
            rem_q      <= '0;
            div_q      <= b_mag;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= (b == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          dq_q  <= {dq_q[N-2:0], qbit};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          // Divide-by-zero waits one cycle here so its result lands two edges after acceptance.
          if (dz_q && cnt_q == '0) begin
            cnt_q <= CW'(1);
          end else begin
            q_q         <= fix_q;
            clip_q      <= fix_clip;
            dzo_q       <= dz_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q         = q_q;
  assign clipping  = clip_q;
  assign div_zero  = dzo_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: scoreboard bench for fp_div_seq (Q16.16) with a reference model.
// Covers directed vectors, random divides, backpressure and mid-operation reset.
module tb_fp_div_seq;

`ifdef FP_DIV_ROUND_EN
  localparam int NST = 49;
  localparam bit RND = 1'b1;
`else
  localparam int NST = 48;
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    logic [31:0] q;
    logic        c;
    logic        z;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] q;
  logic        clipping;
  logic        div_zero;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  exp_t sb[$];

  logic        ov_prev = 1'b0;
  int          rise_cyc = 0;
  logic [31:0] hq;
  logic        hc;
  logic        hz;

  fp_div_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .q        (q),
    .clipping (clipping),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'b0;
    else out_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic exp_t model(input logic [31:0] ia, input logic [31:0] ib);
    exp_t   e;
    longint sa, sbv, ma, mb, num, m, lim;
    bit     neg;
    sa  = longint'($signed(ia));
    sbv = longint'($signed(ib));
    e.acc = 0;
    if (sbv == 0) begin
      e.z   = 1'b1;
      e.lat = 2;
      if (sa == 0) begin
        e.q = 32'h0; e.c = 1'b0;
      end else begin
        e.q = (sa < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        e.c = 1'b1;
      end
      return e;
    end
    e.z   = 1'b0;
    e.lat = NST + 1;
    ma  = (sa < 0) ? -sa : sa;
    mb  = (sbv < 0) ? -sbv : sbv;
    neg = (sa < 0) != (sbv < 0);
    num = ma * 65536;
    if (RND) m = (2 * num + mb) / (2 * mb);
    else m = num / mb;
    lim = neg ? 64'sd2147483648 : 64'sd2147483647;
    if (m > lim) begin
      e.q = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.c = 1'b1;
    end else begin
      e.q = neg ? 32'(-m) : 32'(m);
      e.c = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid) begin
        if (!ov_prev) begin
          rise_cyc = cyc;
          hq = q; hc = clipping; hz = div_zero;
        end else begin
          check("hold_q", q, hq);
          check("hold_flags", {30'd0, clipping, div_zero}, {30'd0, hc, hz});
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_result: got q=%h with empty scoreboard", q);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("q", q, e.q);
            check("clipping", 32'(clipping), 32'(e.c));
            check("div_zero", 32'(div_zero), 32'(e.z));
            check("latency", 32'(rise_cyc - e.acc), 32'(e.lat));
          end
        end
      end
      ov_prev = out_valid;
    end
  end

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL issue_timeout: in_ready=%b, expected 1", in_ready);
      return;
    end
    in_valid = 1'b1;
    a = ia;
    b = ib;
    @(negedge clk);
    e = model(ia, ib);
    e.acc = cyc;
    sb.push_back(e);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || out_valid) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    int n;

    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_q", q, 32'h0);
    check("rst_flags", {30'd0, clipping, div_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    rdy_mode = 0;
    issue(32'h0003_0000, 32'h0002_0000);
    issue(32'hFFFF_0000, 32'h0004_0000);
    issue(32'h0002_0000, 32'h0003_0000);
    issue(32'h7530_0000, 32'h0000_0042);
    issue(32'h8000_0000, 32'hFFFF_0000);
    issue(32'h0005_0000, 32'h0000_0000);
    issue(32'hFFFB_0000, 32'h0000_0000);
    issue(32'h0000_0000, 32'h0000_0000);
    issue(32'hFFFD_0000, 32'hFFFE_0000);
    issue(32'h8000_0000, 32'h0001_0000);
    issue(32'h8000_0000, 32'hFFFF_FFFF);
    issue(32'h0000_0001, 32'h7FFF_FFFF);
    drain();

    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(1, 32'h0003_FFFF));
        2: rb = -32'($urandom_range(1, 32'h0003_FFFF));
        default: rb = (i % 8 == 0) ? 32'h0 : $urandom;
      endcase
      if (i % 5 == 0) ra = 32'($signed(ra) >>> 12);
      issue(ra, rb);
    end
    rdy_mode = 0;
    drain();

    rdy_mode = 1;
    issue(32'h0007_8000, 32'hFFFD_0000);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("bp_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      if (i == 3) begin
        in_valid = 1'b1;
        a = 32'h0001_0000;
        b = 32'h0001_0000;
      end else begin
        in_valid = 1'b0;
      end
    end
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk);
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    drain();

    issue(32'h0064_0000, 32'h0003_0000);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_q", q, 32'h0);
    check("mid_rst_flags", {30'd0, clipping, div_zero}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(32'h0001_0000, 32'h0001_0000);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
